impulse_stim_capture: RTL

//   Synthesisable, parametrised impulse/step stimulus generator with an on-chip response capture RAM.

---
 rtl/impulse_stim_capture_if.sv | 28 ++
 rtl/impulse_stim_capture.sv | 130 +++++++++++++
 2 files changed

// File: rtl/impulse_stim_capture_if.sv
// Bus bundle for impulse_stim_capture: run control, stimulus/response stream,
// capture readback and peak result.
interface impulse_stim_capture_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 5
) ();
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] amplitude;
    logic [DATA_W-1:0] stim_out;
    logic [DATA_W-1:0] resp_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] peak_mag;
    logic [ADDR_W-1:0] peak_idx;

    modport master (
        output start, mode, amplitude, resp_in, rd_addr,
        input  stim_out, rd_data, busy, done, peak_mag, peak_idx
    );

    modport slave (
        input  start, mode, amplitude, resp_in, rd_addr,
        output stim_out, rd_data, busy, done, peak_mag, peak_idx
    );
endinterface

// File: rtl/impulse_stim_capture.sv
// Impulse/step stimulus generator with response capture RAM and readback.
// Optional peak-magnitude tracker enabled by defining CAPTURE_PEAK_EN.
module impulse_stim_capture #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned PERIOD    = 32,
    parameter int unsigned CAP_DEPTH = 32,
    parameter int unsigned ADDR_W    = $clog2(CAP_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    impulse_stim_capture_if.slave bus
);
    localparam int unsigned CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(PERIOD - 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAP_DEPTH - 1);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FIRE, S_CAPTURE, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    arm_cnt_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   amp_q;
    logic                sign_toggle_q;
    logic [DATA_W-1:0]   stim_d;
    logic                busy_d, done_d;
    logic [DATA_W-1:0]   neg_amp_c, fire_val_c;
    logic                accept_c, wr_en_c, step_c, alt_c;
    logic [DATA_W-1:0]   mem [CAP_DEPTH];

    assign accept_c = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign wr_en_c  = (state_q == S_FIRE) || (state_q == S_CAPTURE);
    assign step_c   = (mode_q == 2'b01);
    assign alt_c    = (mode_q == 2'b10);

    // Saturating negation keeps the most negative code from wrapping onto itself
    assign neg_amp_c  = (amp_q == MOST_NEG) ? MOST_POS : (~amp_q + DATA_W'(1));
    assign fire_val_c = (alt_c && sign_toggle_q) ? neg_amp_c : amp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state plus the values the registered outputs take with it
    always_comb begin
        state_d = state_q;
        stim_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:    if (accept_c) state_d = S_ARM;
            S_ARM:     if (arm_cnt_q == ARM_LAST) state_d = S_FIRE;
            S_FIRE:    state_d = S_CAPTURE;
            S_CAPTURE: if (wr_addr_q == LAST_ADDR) state_d = S_DONE;
            S_DONE:    if (accept_c) state_d = S_ARM;
            default:   state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ARM) || (state_d == S_FIRE) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
        if (state_d == S_FIRE || (state_d == S_CAPTURE && step_c)) stim_d = fire_val_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q     <= '0;
            wr_addr_q     <= '0;
            mode_q        <= '0;
            amp_q         <= '0;
            sign_toggle_q <= 1'b0;
            bus.stim_out  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.stim_out <= stim_d;
            bus.busy     <= busy_d;
            bus.done     <= done_d;
            if (accept_c) begin
                arm_cnt_q <= '0;
                wr_addr_q <= '0;
                mode_q    <= bus.mode;
                amp_q     <= bus.amplitude;
            end else begin
                if (state_q == S_ARM) arm_cnt_q <= arm_cnt_q + CNT_W'(1);
                if (wr_en_c && wr_addr_q != LAST_ADDR) wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
            if (state_q == S_CAPTURE && state_d == S_DONE) sign_toggle_q <= ~sign_toggle_q;
        end
    end

    // Capture RAM: contents survive reset; read returns pre-write data
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_addr_q] <= bus.resp_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.rd_data <= '0;
        else          bus.rd_data <= mem[bus.rd_addr];
    end

`ifdef CAPTURE_PEAK_EN
    logic [DATA_W-1:0] resp_abs_c;

    always_comb begin
        resp_abs_c = bus.resp_in;
        if (bus.resp_in == MOST_NEG)     resp_abs_c = MOST_POS;
        else if (bus.resp_in[DATA_W-1])  resp_abs_c = ~bus.resp_in + DATA_W'(1);
    end

    // Strict compare keeps the earliest index on ties
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.peak_mag <= '0;
            bus.peak_idx <= '0;
        end else if (accept_c) begin
            bus.peak_mag <= '0;
            bus.peak_idx <= '0;
        end else if (wr_en_c && resp_abs_c > bus.peak_mag) begin
            bus.peak_mag <= resp_abs_c;
            bus.peak_idx <= wr_addr_q;
        end
    end
`else
    assign bus.peak_mag = '0;
    assign bus.peak_idx = '0;
`endif

endmodule
